// File: rtl/serial_addsub_ctrl_if.sv
// Operand/result bundle for the bit-serial add/subtract controller.
// slave = the arithmetic block, master = whoever issues operations.
interface serial_addsub_ctrl_if;
  logic       start;
  logic       m;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [3:0] s;
  logic       cout;
  logic       ovf;

  modport slave (
    input  start, m, a, b,
    output busy, done, s, cout, ovf
  );

  modport master (
    output start, m, a, b,
    input  busy, done, s, cout, ovf
  );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial 4-bit add/subtract: one accept edge, four LSB-first RUN edges, one DONE cycle.
// Latency is fixed at 5 cycles from accepted start to done; start is ignored while RUN or DONE.
module serial_addsub_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  serial_addsub_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [2:0] r_sum_sh;
  logic [1:0] r_cnt;
  logic       r_m;
  logic       r_carry;
  logic [3:0] r_s;
  logic       r_cout;
  logic       r_ovf;

  logic       w_busy;
  logic       w_done;
  logic       w_accept;
  logic       w_last;
  logic       w_bc;
  logic       w_sum_bit;
  logic       w_carry_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (r_cnt == 2'd3) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_accept    = (r_state == S_IDLE) && bus.start;
  assign w_last      = (r_state == S_RUN) && (r_cnt == 2'd3);

  // Subtract is a + ~b + 1: b is inverted per bit and the carry is seeded with m.
  assign w_bc        = r_b[0] ^ r_m;
  assign w_sum_bit   = r_a[0] ^ w_bc ^ r_carry;
  assign w_carry_nxt = (r_a[0] & w_bc) | (r_a[0] & r_carry) | (w_bc & r_carry);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= 4'd0;
      r_b      <= 4'd0;
      r_sum_sh <= 3'd0;
      r_cnt    <= 2'd0;
      r_m      <= 1'b0;
      r_carry  <= 1'b0;
      r_s      <= 4'd0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= bus.a;
      r_b      <= bus.b;
      r_m      <= bus.m;
      r_carry  <= bus.m;
      r_cnt    <= 2'd0;
      r_sum_sh <= 3'd0;
    end else if (r_state == S_RUN) begin
      r_a      <= {1'b0, r_a[3:1]};
      r_b      <= {1'b0, r_b[3:1]};
      r_sum_sh <= {w_sum_bit, r_sum_sh[2:1]};
      r_carry  <= w_carry_nxt;
      r_cnt    <= r_cnt + 2'd1;
      // Results are published only on the final bit so s never shows a partial sum.
      if (w_last) begin
        r_s    <= {w_sum_bit, r_sum_sh};
        r_cout <= w_carry_nxt;
        r_ovf  <= r_carry ^ w_carry_nxt;
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.s    = r_s;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: scoreboard of expected results
// pushed at start, popped when done is seen.
module tb_serial_addsub_ctrl;

  typedef struct packed {
    logic [3:0] s;
    logic       cout;
    logic       ovf;
  } res_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  res_t sb_q[$];
  res_t hold;

  serial_addsub_ctrl_if bus_if ();

  serial_addsub_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: plain 5-bit addition of a and the (possibly inverted) b.
  function automatic res_t model(input logic [3:0] a, input logic [3:0] b, input logic m);
    res_t       r;
    logic [3:0] bb;
    logic [4:0] t;
    bb     = m ? ~b : b;
    t      = {1'b0, a} + {1'b0, bb} + {4'd0, m};
    r.s    = t[3:0];
    r.cout = t[4];
    r.ovf  = (a[3] == bb[3]) && (t[3] != a[3]);
    return r;
  endfunction

  function automatic res_t dut_res();
    res_t r;
    r.s    = bus_if.s;
    r.cout = bus_if.cout;
    r.ovf  = bus_if.ovf;
    return r;
  endfunction

  task automatic test_reset();
    rst          = 1'b1;
    bus_if.start = 1'b1;
    bus_if.a     = 4'hF;
    bus_if.b     = 4'hF;
    bus_if.m     = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({bus_if.busy, bus_if.done, dut_res()} !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_state: got busy=%b done=%b s=%b cout=%b ovf=%b, want all 0",
               bus_if.busy, bus_if.done, bus_if.s, bus_if.cout, bus_if.ovf);
    end
    rst          = 1'b0;
    bus_if.start = 1'b0;
    tick();
    n_checks++;
    if (bus_if.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL start_during_rst: busy=%b, want 0", bus_if.busy);
    end
    hold = '0;
  endtask

  // One start pulse; checks busy in cycles 1-4, held outputs, done in cycle 5.
  task automatic run_op(input string name, input logic [3:0] a, input logic [3:0] b,
                        input logic m, input res_t exp);
    res_t got;
    res_t want;
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.m     = m;
    bus_if.start = 1'b1;
    sb_q.push_back(exp);
    tick();
    bus_if.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if ({bus_if.busy, bus_if.done} !== 2'b10) begin
        n_errors++;
        $display("FAIL %s_busy_c%0d: busy=%b done=%b, want busy=1 done=0",
                 name, k, bus_if.busy, bus_if.done);
      end
      n_checks++;
      if (dut_res() !== hold) begin
        n_errors++;
        $display("FAIL %s_hold_c%0d: got %h, want held %h", name, k, dut_res(), hold);
      end
      tick();
    end
    n_checks++;
    if ({bus_if.busy, bus_if.done} !== 2'b01) begin
      n_errors++;
      $display("FAIL %s_done_c5: busy=%b done=%b, want busy=0 done=1",
               name, bus_if.busy, bus_if.done);
    end
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s_sb_empty: got empty scoreboard, want one entry", name);
    end else begin
      want = sb_q.pop_front();
      got  = dut_res();
      if (got !== want) begin
        n_errors++;
        $display("FAIL %s_result: got s=%b cout=%b ovf=%b, want s=%b cout=%b ovf=%b",
                 name, got.s, got.cout, got.ovf, want.s, want.cout, want.ovf);
      end
      hold = want;
    end
    tick();
    n_checks++;
    if (bus_if.done !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_done_width: done=%b in cycle 6, want 0", name, bus_if.done);
    end
  endtask

  task automatic test_vectors();
    run_op("add_5p3",  4'b0101, 4'b0011, 1'b0, '{s: 4'b1000, cout: 1'b0, ovf: 1'b1});
    run_op("sub_7m2",  4'b0111, 4'b0010, 1'b1, '{s: 4'b0101, cout: 1'b1, ovf: 1'b0});
    run_op("sub_0m1",  4'b0000, 4'b0001, 1'b1, '{s: 4'b1111, cout: 1'b0, ovf: 1'b0});
    run_op("sub_8m1",  4'b1000, 4'b0001, 1'b1, '{s: 4'b0111, cout: 1'b1, ovf: 1'b1});
    for (int i = 0; i < 4; i++) begin
      logic [3:0] ra;
      logic [3:0] rb;
      logic       rm;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rm = 1'($urandom_range(0, 1));
      run_op("rand", ra, rb, rm, model(ra, rb, rm));
    end
  endtask

  task automatic test_midrun_change();
    res_t want;
    res_t got;
    bus_if.a     = 4'b0110;
    bus_if.b     = 4'b0111;
    bus_if.m     = 1'b0;
    bus_if.start = 1'b1;
    sb_q.push_back(model(4'b0110, 4'b0111, 1'b0));
    tick();
    for (int k = 1; k <= 4; k++) begin
      bus_if.a     = 4'($urandom_range(0, 15));
      bus_if.b     = 4'($urandom_range(0, 15));
      bus_if.m     = ~bus_if.m;
      bus_if.start = k[0];
      tick();
    end
    bus_if.start = 1'b0;
    n_checks++;
    if (bus_if.done !== 1'b1) begin
      n_errors++;
      $display("FAIL midrun_done: done=%b in cycle 5, want 1", bus_if.done);
    end
    n_checks++;
    want = sb_q.pop_front();
    got  = dut_res();
    if (got !== want) begin
      n_errors++;
      $display("FAIL midrun_result: got %h, want %h", got, want);
    end
    hold = want;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if ({bus_if.busy, bus_if.done} !== 2'b00) begin
        n_errors++;
        $display("FAIL midrun_extra_c%0d: busy=%b done=%b, want 0 0", k + 6, bus_if.busy, bus_if.done);
      end
    end
  endtask

  task automatic test_reset_midrun();
    bus_if.a     = 4'b1111;
    bus_if.b     = 4'b1111;
    bus_if.m     = 1'b0;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({bus_if.busy, bus_if.done, dut_res()} !== 8'd0) begin
      n_errors++;
      $display("FAIL rst_midrun_zero: got busy=%b done=%b s=%b cout=%b ovf=%b, want all 0",
               bus_if.busy, bus_if.done, bus_if.s, bus_if.cout, bus_if.ovf);
    end
    hold = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (bus_if.done !== 1'b0) begin
        n_errors++;
        $display("FAIL rst_midrun_nodone_c%0d: done=%b, want 0", k, bus_if.done);
      end
    end
    run_op("after_rst", 4'b0011, 4'b0100, 1'b1, model(4'b0011, 4'b0100, 1'b1));
  endtask

  task automatic test_back_to_back();
    int   done_cyc[$];
    res_t want;
    res_t exp;
    exp          = model(4'b1001, 4'b0110, 1'b0);
    bus_if.a     = 4'b1001;
    bus_if.b     = 4'b0110;
    bus_if.m     = 1'b0;
    bus_if.start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i < 20 && (i % 6) == 0) sb_q.push_back(exp);
      if (i == 20) bus_if.start = 1'b0;
      tick();
      if (bus_if.done === 1'b1) begin
        done_cyc.push_back(i + 1);
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL b2b_unexpected_done: cycle %0d, want no done", i + 1);
        end else begin
          want = sb_q.pop_front();
          if (dut_res() !== want) begin
            n_errors++;
            $display("FAIL b2b_result: got %h, want %h", dut_res(), want);
          end
        end
      end
    end
    n_checks++;
    if (done_cyc.size() != 4) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d done pulses, want 4", done_cyc.size());
    end
    for (int j = 1; j < done_cyc.size(); j++) begin
      n_checks++;
      if (done_cyc[j] - done_cyc[j-1] != 6) begin
        n_errors++;
        $display("FAIL b2b_spacing: got %0d cycles, want 6", done_cyc[j] - done_cyc[j-1]);
      end
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL b2b_leftover: got %0d pending results, want 0", sb_q.size());
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.a     = 4'd0;
    bus_if.b     = 4'd0;
    bus_if.m     = 1'b0;
    hold         = '0;
    test_reset();
    test_vectors();
    test_midrun_change();
    test_reset_midrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
